// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-channel cache-to-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_priority_picker.sv
// Picks one requester: lowest index (fixed) or first at/after the pointer (round-robin).
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = ARB_RR,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_rr_ptr,
    output logic [NUM_CH-1:0] o_grant_oh,
    output logic [CH_W-1:0]   o_grant_idx
);

    int            w_base;
    int            w_cand;
    logic [CH_W-1:0] w_idx;
    logic          w_found;

    // NOTE: every variable written in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        w_idx       = '0;
        w_base      = (RR_MODE == ARB_RR) ? int'(i_rr_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = w_base + k;
            if (w_cand >= NUM_CH) begin
                w_cand = w_cand - NUM_CH;
            end
            w_idx = CH_W'(w_cand);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// Funnels NUM_CH cache miss/writeback channels onto one memory port, with
// multi-beat write forwarding and tag-based read response routing.
module mem_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_BITS   = 28,
    parameter int DATA_BITS   = 128,
    parameter int TAG_BITS    = 5,
    parameter int WRITE_BEATS = 4,
    parameter int RR_MODE     = ARB_RR
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_CH-1:0]             ch_req_valid,
    output logic [NUM_CH-1:0]             ch_req_ready,
    input  logic [NUM_CH-1:0]             ch_req_rw,
    input  logic [NUM_CH*ADDR_BITS-1:0]   ch_req_addr,

    input  logic [NUM_CH-1:0]             ch_data_valid,
    output logic [NUM_CH-1:0]             ch_data_ready,
    input  logic [NUM_CH*DATA_BITS-1:0]   ch_data_bits,
    input  logic [NUM_CH*DATA_BITS/8-1:0] ch_data_mask,

    output logic [NUM_CH-1:0]             ch_resp_valid,
    output logic [DATA_BITS-1:0]          ch_resp_data,

    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_rw,
    output logic [ADDR_BITS-1:0]          mem_req_addr,
    output logic [TAG_BITS-1:0]           mem_req_tag,

    output logic                          mem_req_data_valid,
    input  logic                          mem_req_data_ready,
    output logic [DATA_BITS-1:0]          mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]        mem_req_data_mask,

    input  logic                          mem_resp_valid,
    input  logic [DATA_BITS-1:0]          mem_resp_data,
    input  logic [TAG_BITS-1:0]           mem_resp_tag,

    output logic                          tag_err
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BEAT_W = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;
    localparam int MASK_W = DATA_BITS / 8;

    if (NUM_CH < 2) begin : g_chk_num_ch
        $error("mem_arbiter_n: NUM_CH must be at least 2");
    end
    if (TAG_BITS < CH_W) begin : g_chk_tag_bits
        $error("mem_arbiter_n: TAG_BITS too narrow to carry a channel index");
    end
    if (WRITE_BEATS < 1) begin : g_chk_beats
        $error("mem_arbiter_n: WRITE_BEATS must be at least 1");
    end

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [CH_W-1:0]    r_grant;
    logic [CH_W-1:0]    w_grant_nxt;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [CH_W-1:0]    w_rr_ptr_nxt;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0]  w_beat_cnt_nxt;
    logic               r_tag_err;

    logic [NUM_CH-1:0]  w_pick_oh;
    logic [CH_W-1:0]    w_pick_idx;
    logic               w_any_req;

    logic               w_sel_rw;
    logic [ADDR_BITS-1:0] w_sel_addr;
    logic               w_sel_dvalid;
    logic [DATA_BITS-1:0] w_sel_bits;
    logic [MASK_W-1:0]  w_sel_mask;
    logic [CH_W-1:0]    w_grant_inc;
    logic               w_last_beat;
    logic               w_beat_hs;
    logic               w_tag_bad;

    rr_priority_picker #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .CH_W    (CH_W)
    ) u_picker (
        .i_req       (ch_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx)
    );

    assign w_any_req = |w_pick_oh;

    // The granted channel's request and data paths are steered straight through.
    assign w_sel_rw     = ch_req_rw[r_grant];
    assign w_sel_addr   = ch_req_addr[int'(r_grant)*ADDR_BITS +: ADDR_BITS];
    assign w_sel_dvalid = ch_data_valid[r_grant];
    assign w_sel_bits   = ch_data_bits[int'(r_grant)*DATA_BITS +: DATA_BITS];
    assign w_sel_mask   = ch_data_mask[int'(r_grant)*MASK_W +: MASK_W];

    assign w_grant_inc  = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
    assign w_last_beat  = (r_beat_cnt == BEAT_W'(WRITE_BEATS - 1));
    assign w_beat_hs    = w_sel_dvalid && mem_req_data_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_beat_cnt_nxt     = r_beat_cnt;
        ch_req_ready       = '0;
        ch_data_ready      = '0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = REQ;
                end
            end

            REQ: begin
                mem_req_valid         = 1'b1;
                mem_req_rw            = w_sel_rw;
                mem_req_addr          = w_sel_addr;
                mem_req_tag           = TAG_BITS'(r_grant);
                ch_req_ready[r_grant] = mem_req_ready;
                if (mem_req_ready) begin
                    if (w_sel_rw) begin
                        w_state_nxt    = WDATA;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_grant_inc;
                    end
                end
            end

            WDATA: begin
                mem_req_data_valid     = w_sel_dvalid;
                mem_req_data_bits      = w_sel_bits;
                mem_req_data_mask      = w_sel_mask;
                ch_data_ready[r_grant] = mem_req_data_ready;
                if (w_beat_hs) begin
                    if (w_last_beat) begin
                        w_state_nxt    = IDLE;
                        w_rr_ptr_nxt   = w_grant_inc;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Responses bypass the FSM entirely; out-of-range tags match no channel.
    always_comb begin
        ch_resp_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mem_resp_valid && (mem_resp_tag == TAG_BITS'(i))) begin
                ch_resp_valid[i] = 1'b1;
            end
        end
    end

    assign ch_resp_data = mem_resp_data;
    assign w_tag_bad    = mem_resp_valid &&
                          ({1'b0, mem_resp_tag} >= (TAG_BITS + 1)'(NUM_CH));
    assign tag_err      = r_tag_err;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (w_tag_bad) begin
                r_tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven side by side.
module tb_mem_arbiter_n;
    import mem_arb_pkg::*;

    localparam int NC = 3;
    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;
    localparam int WB = 4;
    localparam int MB = DB / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     ch_req_valid;
    logic [NC-1:0]     ch_req_rw;
    logic [NC*AB-1:0]  ch_req_addr;
    logic [NC-1:0]     ch_data_valid;
    logic [NC*DB-1:0]  ch_data_bits;
    logic [NC*MB-1:0]  ch_data_mask;
    logic              mem_req_ready;
    logic              mem_req_data_ready;
    logic              mem_resp_valid;
    logic [DB-1:0]     mem_resp_data;
    logic [TB-1:0]     mem_resp_tag;

    logic [NC-1:0] rr_ch_req_ready, rr_ch_data_ready, rr_ch_resp_valid;
    logic [DB-1:0] rr_ch_resp_data, rr_mem_req_data_bits;
    logic          rr_mem_req_valid, rr_mem_req_rw, rr_mem_req_data_valid, rr_tag_err;
    logic [AB-1:0] rr_mem_req_addr;
    logic [TB-1:0] rr_mem_req_tag;
    logic [MB-1:0] rr_mem_req_data_mask;

    logic [NC-1:0] fx_ch_req_ready, fx_ch_data_ready, fx_ch_resp_valid;
    logic [DB-1:0] fx_ch_resp_data, fx_mem_req_data_bits;
    logic          fx_mem_req_valid, fx_mem_req_rw, fx_mem_req_data_valid, fx_tag_err;
    logic [AB-1:0] fx_mem_req_addr;
    logic [TB-1:0] fx_mem_req_tag;
    logic [MB-1:0] fx_mem_req_data_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_n #(
        .NUM_CH(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB),
        .WRITE_BEATS(WB), .RR_MODE(ARB_RR)
    ) dut_rr (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(rr_ch_req_ready),
        .ch_req_rw(ch_req_rw), .ch_req_addr(ch_req_addr),
        .ch_data_valid(ch_data_valid), .ch_data_ready(rr_ch_data_ready),
        .ch_data_bits(ch_data_bits), .ch_data_mask(ch_data_mask),
        .ch_resp_valid(rr_ch_resp_valid), .ch_resp_data(rr_ch_resp_data),
        .mem_req_valid(rr_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(rr_mem_req_rw), .mem_req_addr(rr_mem_req_addr), .mem_req_tag(rr_mem_req_tag),
        .mem_req_data_valid(rr_mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(rr_mem_req_data_bits), .mem_req_data_mask(rr_mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
        .tag_err(rr_tag_err)
    );

    mem_arbiter_n #(
        .NUM_CH(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB),
        .WRITE_BEATS(WB), .RR_MODE(ARB_FIXED)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(fx_ch_req_ready),
        .ch_req_rw(ch_req_rw), .ch_req_addr(ch_req_addr),
        .ch_data_valid(ch_data_valid), .ch_data_ready(fx_ch_data_ready),
        .ch_data_bits(ch_data_bits), .ch_data_mask(ch_data_mask),
        .ch_resp_valid(fx_ch_resp_valid), .ch_resp_data(fx_ch_resp_data),
        .mem_req_valid(fx_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(fx_mem_req_rw), .mem_req_addr(fx_mem_req_addr), .mem_req_tag(fx_mem_req_tag),
        .mem_req_data_valid(fx_mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(fx_mem_req_data_bits), .mem_req_data_mask(fx_mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
        .tag_err(fx_tag_err)
    );

    // Every handshake/valid output packed together, for "all quiet" checks.
    wire [11:0] rr_ctl = {rr_ch_req_ready, rr_ch_data_ready, rr_ch_resp_valid,
                          rr_mem_req_valid, rr_mem_req_data_valid, rr_tag_err};
    wire [11:0] fx_ctl = {fx_ch_req_ready, fx_ch_data_ready, fx_ch_resp_valid,
                          fx_mem_req_valid, fx_mem_req_data_valid, fx_tag_err};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AB-1:0] addr_of(input int ch);
        case (ch)
            0:       return 28'h1000;
            1:       return 28'h2000;
            default: return 28'h3000;
        endcase
    endfunction

    // Protocol monitor: the granted channel must hold its request while it is offered to memory.
    always @(negedge clk) begin
        if (!reset && rr_mem_req_valid)
            check("req_hold_rr", 128'(ch_req_valid[rr_mem_req_tag[1:0]]), 128'd1);
        if (!reset && fx_mem_req_valid)
            check("req_hold_fx", 128'(ch_req_valid[fx_mem_req_tag[1:0]]), 128'd1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tag;
        int hs;
        int cyc;

        reset              = 1'b1;
        ch_req_valid       = 3'b111;
        ch_req_rw          = 3'b000;
        ch_req_addr        = {28'h3000, 28'h2000, 28'h1000};
        ch_data_valid      = 3'b000;
        ch_data_bits       = '0;
        ch_data_mask       = {16'hFFFF, 16'h00FF, 16'hF0F0};
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        mem_resp_tag       = '0;

        // 1: reset held with every channel requesting
        repeat (3) begin
            step();
            check("rst_ctl_rr", 128'(rr_ctl), 128'd0);
            check("rst_ctl_fx", 128'(fx_ctl), 128'd0);
            check("rst_addr_rr", 128'(rr_mem_req_addr), 128'd0);
        end
        reset = 1'b0;

        // 2 + 3: continuous reads on all channels, memory always ready
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 0) begin
                exp_tag = (k / 2) % 3;
                check("rd_valid_rr", 128'(rr_mem_req_valid), 128'd1);
                check("rd_tag_rr",   128'(rr_mem_req_tag), 128'(exp_tag));
                check("rd_addr_rr",  128'(rr_mem_req_addr), 128'(addr_of(exp_tag)));
                check("rd_rw_rr",    128'(rr_mem_req_rw), 128'd0);
                check("rd_ready_rr", 128'(rr_ch_req_ready), 128'(3'b001 << exp_tag));
                check("rd_valid_fx", 128'(fx_mem_req_valid), 128'd1);
                check("rd_tag_fx",   128'(fx_mem_req_tag), 128'd0);
                check("rd_ready_fx", 128'(fx_ch_req_ready), 128'(3'b001));
            end else begin
                check("rd_gap_rr", 128'(rr_mem_req_valid), 128'd0);
                check("rd_gap_fx", 128'(fx_mem_req_valid), 128'd0);
                check("rd_gap_ready_rr", 128'(rr_ch_req_ready), 128'd0);
            end
        end
        ch_req_valid = 3'b000;

        // 4: ch1 write, four beats, data_ready toggling, junk data on other channels
        ch_req_valid = 3'b010;
        ch_req_rw    = 3'b010;
        ch_req_addr[AB +: AB] = 28'h100;
        ch_data_valid = 3'b111;
        ch_data_bits[0 +: DB]    = '1;
        ch_data_bits[2*DB +: DB] = '1;
        step();
        check("wr_req_valid_rr", 128'(rr_mem_req_valid), 128'd1);
        check("wr_req_rw_rr",    128'(rr_mem_req_rw), 128'd1);
        check("wr_req_addr_rr",  128'(rr_mem_req_addr), 128'h100);
        check("wr_req_tag_rr",   128'(rr_mem_req_tag), 128'd1);
        check("wr_req_ready_rr", 128'(rr_ch_req_ready), 128'(3'b010));
        check("wr_req_tag_fx",   128'(fx_mem_req_tag), 128'd1);
        step();
        ch_req_valid = 3'b000;
        hs  = 0;
        cyc = 0;
        mem_req_data_ready = 1'b1;
        while (hs < WB && cyc < 20) begin
            ch_data_bits[DB +: DB] = 128'hA + 128'(hs);
            #1;
            if (mem_req_data_ready) begin
                check("wr_dvalid_rr", 128'(rr_mem_req_data_valid), 128'd1);
                check("wr_bits_rr",   rr_mem_req_data_bits, 128'hA + 128'(hs));
                check("wr_bits_fx",   fx_mem_req_data_bits, 128'hA + 128'(hs));
                check("wr_dready_rr", 128'(rr_ch_data_ready), 128'(3'b010));
                if (hs == 0)
                    check("wr_mask_rr", 128'(rr_mem_req_data_mask), 128'h00FF);
                if (rr_mem_req_data_valid)
                    hs++;
            end else begin
                check("wr_dready_stall_rr", 128'(rr_ch_data_ready), 128'd0);
            end
            step();
            mem_req_data_ready = ~mem_req_data_ready;
            cyc++;
        end
        check("wr_beats", 128'(hs), 128'(WB));
        mem_req_data_ready = 1'b1;
        #1;
        check("wr_done_dvalid_rr", 128'(rr_mem_req_data_valid), 128'd0);
        check("wr_done_dready_rr", 128'(rr_ch_data_ready), 128'd0);
        check("wr_done_dvalid_fx", 128'(fx_mem_req_data_valid), 128'd0);
        check("wr_done_req_rr",    128'(rr_mem_req_valid), 128'd0);

        // 5: responses during a ch0 write
        ch_data_valid = 3'b001;
        ch_req_valid  = 3'b001;
        ch_req_rw     = 3'b001;
        step();
        check("rsp_req_tag_rr", 128'(rr_mem_req_tag), 128'd0);
        check("rsp_req_rw_rr",  128'(rr_mem_req_rw), 128'd1);
        step();
        ch_req_valid   = 3'b000;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd2;
        mem_resp_data  = 128'hDEAD_BEEF;
        #1;
        check("rsp2_valid_rr", 128'(rr_ch_resp_valid), 128'(3'b100));
        check("rsp2_valid_fx", 128'(fx_ch_resp_valid), 128'(3'b100));
        check("rsp2_data_rr",  rr_ch_resp_data, 128'hDEAD_BEEF);
        check("rsp2_dvalid_rr", 128'(rr_mem_req_data_valid), 128'd1);
        check("rsp2_err_rr",   128'(rr_tag_err), 128'd0);
        step();
        mem_resp_tag = 5'd3;
        #1;
        check("rsp3_valid_rr", 128'(rr_ch_resp_valid), 128'd0);
        check("rsp3_valid_fx", 128'(fx_ch_resp_valid), 128'd0);
        check("rsp3_err_pre_rr", 128'(rr_tag_err), 128'd0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("rsp3_err_rr", 128'(rr_tag_err), 128'd1);
        check("rsp3_err_fx", 128'(fx_tag_err), 128'd1);
        check("rsp_wr_dvalid_rr", 128'(rr_mem_req_data_valid), 128'd1);
        step();
        check("rsp_err_hold_rr", 128'(rr_tag_err), 128'd1);
        check("rsp_wr_last_rr", 128'(rr_mem_req_data_valid), 128'd1);
        step();
        check("rsp_wr_done_rr", 128'(rr_mem_req_data_valid), 128'd0);
        check("rsp_wr_done_fx", 128'(fx_mem_req_data_valid), 128'd0);
        check("rsp_err_sticky_rr", 128'(rr_tag_err), 128'd1);

        // 6: reset after two beats of a ch0 write, then a clean ch2 read
        ch_req_valid = 3'b001;
        ch_req_rw    = 3'b001;
        step();
        step();
        ch_req_valid = 3'b000;
        step();
        step();
        check("abort_beats_rr", 128'(dut_rr.r_beat_cnt), 128'd2);
        reset              = 1'b1;
        mem_req_data_ready = 1'b0;
        ch_req_valid       = 3'b100;
        ch_req_rw          = 3'b000;
        step();
        check("abort_ctl_rr",   128'(rr_ctl), 128'd0);
        check("abort_ctl_fx",   128'(fx_ctl), 128'd0);
        check("abort_beat_rr",  128'(dut_rr.r_beat_cnt), 128'd0);
        check("abort_state_rr", 128'(dut_rr.r_state), 128'(IDLE));
        reset = 1'b0;
        step();
        check("post_valid_rr", 128'(rr_mem_req_valid), 128'd1);
        check("post_tag_rr",   128'(rr_mem_req_tag), 128'd2);
        check("post_addr_rr",  128'(rr_mem_req_addr), 128'h3000);
        check("post_rw_rr",    128'(rr_mem_req_rw), 128'd0);
        check("post_tag_fx",   128'(fx_mem_req_tag), 128'd2);
        step();
        ch_req_valid = 3'b000;
        #1;
        check("post_idle_rr", 128'(rr_mem_req_valid), 128'd0);
        check("post_idle_dv_rr", 128'(rr_mem_req_data_valid), 128'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
